mac_row_ws_os: RTL and testbench
================================

MAC_ROW_WS_OS -- requirements
Module: mac_row_ws_os

Interface
REQ-001 Parameter BW, default 4: activation/weight width in bits.
REQ-002 Parameter PSUM_BW, default 16: partial-sum/accumulator width in bits, signed.
REQ-003 Parameter COL, default 8: number of processing elements (PEs) in the row, minimum 1.
REQ-004 Parameter CNT_MAX, default 72: OS accumulations per output (kij_max*input_ch).
REQ-005 Port clk input 1: single clock; all state updates on its rising edge.
REQ-006 Port reset input 1: asynchronous, active-high reset.
REQ-007 Port os input 1: mode select, 0 = weight-stationary (WS), 1 = output-stationary (OS); sampled only in IDLE.
REQ-008 Port in_w input BW: unsigned activation entering PE0.
REQ-009 Port inst_w input 2: bit0 = weight-load token (WS only), bit1 = execute token.
REQ-010 Port in_n input COL*PSUM_BW: slice i = WS partial sum for PE i; in OS, low BW bits = signed weight for PE i.
REQ-011 Port os_drain input 1: single-cycle request to unload OS accumulators.
REQ-012 Port out_s output COL*PSUM_BW: slice i = PE i result, registered.
REQ-013 Port valid output COL: bit i = out_s slice i valid this cycle.
REQ-014 Port busy output 1: high in any state except IDLE.
REQ-015 Port drain_err output 1: one-cycle pulse when os_drain is rejected.

Function
REQ-016 FSM states IDLE, WS_RUN, OS_ACC, OS_DRAIN; state register and all PE registers reset to IDLE/zero.
REQ-017 IDLE with inst_w != 0: go to WS_RUN if os=0, else OS_ACC; the token is processed that same cycle.
REQ-018 Activation and inst tokens move one PE per cycle: PE0 sees in_w/inst_w directly, PE i sees them i cycles later.
REQ-019 Product = zero-extended activation times signed weight, sign-extended to PSUM_BW.
REQ-020 WS load: an unloaded PE captures the activation under a load token as its weight, sets its loaded flag and consumes the token (not forwarded); a loaded PE forwards it.
REQ-021 WS execute: PE i registers out_s[i] = in_n[i] + product and asserts valid[i] for exactly one cycle, one cycle after the execute token reaches PE i.
REQ-022 WS_RUN returns to IDLE once no token has been in flight for COL consecutive cycles; loaded flags persist.
REQ-023 OS execute: PE i adds product (in_n[i] low BW bits as weight) to acc[i] and increments cnt[i]; once cnt[i]==CNT_MAX, further execute tokens are ignored at PE i but still forwarded.
REQ-024 In OS_ACC, load tokens are ignored and valid = 0.
REQ-025 os_drain in OS_ACC with every cnt[i]==CNT_MAX: go to OS_DRAIN.
REQ-026 OS_DRAIN lasts one cycle: out_s[i]=acc[i], valid all ones; then all acc and cnt clear and the FSM returns to IDLE.
REQ-027 os_drain in any other state, or with any cnt[i]<CNT_MAX: ignored; drain_err pulses the next cycle.
REQ-028 inst_w asserted during OS_DRAIN is dropped; the bench must hold inst_w = 0 while busy and in OS_DRAIN.
REQ-029 Any transition to WS_RUN or OS_ACC whose mode differs from the previous run clears all loaded flags.
REQ-030 valid = 0 and out_s holds its last value whenever no result is produced.

Reset
REQ-031 reset asserted forces asynchronously: state IDLE; out_s, valid, busy, drain_err, acc, cnt, weights, loaded flags and pipeline registers to 0.
REQ-032 Reset mid-operation aborts the run; no partial result is emitted after release.

Configuration
REQ-033 Macro MAC_ROW_WS_OS_SAT_EN defined: WS additions and OS accumulations saturate to the signed PSUM_BW range.
REQ-034 Macro MAC_ROW_WS_OS_SAT_EN undefined: additions wrap modulo 2^PSUM_BW.

Verification (COL=8, BW=4, PSUM_BW=16, CNT_MAX=72)
REQ-035 Load weights (i-3) for PE i over 8 cycles, then execute with in_w=2, in_n=0 -> out_s[i]=2*(i-3), valid[i] one-cycle pulse at execute-start+i+1.
REQ-036 OS: weights 1 in all columns, in_w=3 for 72 execute cycles, then os_drain -> next cycle out_s all 216, valid=0xFF for one cycle, then busy=0.
REQ-037 OS: os_drain after 10 executes -> drain_err pulse, state stays OS_ACC, accumulators unchanged.
REQ-038 WS: in_n[0]=32767, weight 7, activation 7 -> out_s[0]=32767 with the macro defined; -32720 without it.
REQ-039 Reset mid-OS_ACC, restart OS and issue os_drain immediately -> drain_err pulse; all out_s=0, valid=0.

Source files
------------

// File: rtl/mac_row_ws_os.sv
// -----------------------------------------------------------------------------
// mac_row_ws_os
//   One row of COL multiply-accumulate PEs. The row runs in one of two modes:
//   weight-stationary (WS) or output-stationary (OS).
//   - WS: weights are loaded into the PEs from the activation stream. An
//     execute token adds the product to the partial sum arriving on in_n.
//   - OS: the weight comes from in_n and the product is accumulated locally,
//     up to CNT_MAX times. os_drain then unloads all accumulators at once.
//
//   Optional feature: define MAC_ROW_WS_OS_SAT_EN to make WS additions and OS
//   accumulations saturate to the signed PSUM_BW range. Without it they wrap.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   os          mode select (0 = WS, 1 = OS); sampled only while idle
//   in_w        unsigned activation entering PE0
//   inst_w      bit0 = weight-load token (WS), bit1 = execute token
//   in_n        per-PE slice: WS partial sum / OS weight (low BW bits)
//   os_drain    single-cycle request to unload the OS accumulators
//   out_s       per-PE registered result
//   valid       per-PE result strobe
//   busy        high whenever the FSM is not IDLE
//   drain_err   one-cycle pulse when os_drain is rejected
//   dbg_state_o current FSM state, for observation only
//
// Output handshake: valid[i] is a one-cycle strobe with no back-pressure.
// out_s slice i carries a new result only in a cycle where valid[i] is high.
// In every other cycle out_s holds its last value.
// -----------------------------------------------------------------------------
module mac_row_ws_os #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int COL     = 8,
    parameter int CNT_MAX = 72
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   os,
    input  logic [BW-1:0]          in_w,
    input  logic [1:0]             inst_w,
    input  logic [COL*PSUM_BW-1:0] in_n,
    input  logic                   os_drain,
    output logic [COL*PSUM_BW-1:0] out_s,
    output logic [COL-1:0]         valid,
    output logic                   busy,
    output logic                   drain_err,
    output logic [1:0]             dbg_state_o
);

    localparam int CNT_W  = $clog2(CNT_MAX + 1);
    localparam int IDLE_W = $clog2(COL + 1);

    typedef enum logic [1:0] {IDLE, WS_RUN, OS_ACC, OS_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic                last_os_q;
    logic                drain_err_q;

    logic                mode_os, proc_en, clr_loaded, drain_ok, drain_go, any_tok;
    logic [COL-1:0]      cnt_full;
    logic [BW-1:0]       act_in   [COL];
    logic [1:0]          inst_in  [COL];
    logic [1:0]          inst_out [COL];

    // Zero-extended activation times signed weight, sign-extended to PSUM_BW.
    function automatic logic signed [PSUM_BW-1:0] prod_fn(input logic [BW-1:0] a,
                                                          input logic signed [BW-1:0] w);
        logic signed [2*BW:0] p;
        p = $signed({1'b0, a}) * w;
        return PSUM_BW'(p);
    endfunction

    function automatic logic signed [PSUM_BW-1:0] add_fn(input logic signed [PSUM_BW-1:0] a,
                                                         input logic signed [PSUM_BW-1:0] b);
        logic signed [PSUM_BW:0] s;
        s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
`ifdef MAC_ROW_WS_OS_SAT_EN
        if (s[PSUM_BW] != s[PSUM_BW-1])
            return s[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
`endif
        return s[PSUM_BW-1:0];
    endfunction

    // While idle, the mode comes straight from os so that the first token is
    // processed in the same cycle as the transition out of IDLE.
    assign mode_os    = (state_q == IDLE) ? os : (state_q == OS_ACC);
    assign proc_en    = (state_q != OS_DRAIN);
    assign clr_loaded = (state_q == IDLE) && (inst_w != 2'b00) && (os != last_os_q);
    assign drain_ok   = (state_q == OS_ACC) && (&cnt_full);
    assign drain_go   = os_drain && drain_ok;

    assign act_in[0]  = in_w;
    assign inst_in[0] = (state_q == OS_DRAIN) ? 2'b00 : inst_w;

    always_comb begin
        any_tok = (inst_w != 2'b00);
        for (int i = 0; i < COL; i++) any_tok = any_tok | (|inst_out[i]);
    end

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        case (state_q)
            IDLE:     if (inst_w != 2'b00) state_d = os ? OS_ACC : WS_RUN;
            WS_RUN: begin
                if (!any_tok) begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    if (idle_cnt_q == IDLE_W'(COL - 1)) state_d = IDLE;
                end
            end
            OS_ACC:   if (drain_go) state_d = OS_DRAIN;
            OS_DRAIN: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idle_cnt_q  <= '0;
            last_os_q   <= 1'b0;
            drain_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            drain_err_q <= os_drain && !drain_ok;
            if ((state_q == IDLE) && (inst_w != 2'b00)) last_os_q <= os;
        end
    end

    assign busy        = (state_q != IDLE);
    assign drain_err   = drain_err_q;
    assign dbg_state_o = state_q;

    for (genvar i = 0; i < COL; i++) begin : g_pe
        logic signed [BW-1:0]      w_q, w_d;
        logic                      ld_q, ld_d, ld_eff;
        logic signed [PSUM_BW-1:0] acc_q, acc_d, out_q, out_d;
        logic [CNT_W-1:0]          cnt_q, cnt_d;
        logic                      vld_q, vld_d;
        logic [1:0]                fwd_q, fwd_d;
        logic [PSUM_BW-1:0]        n_slice;

        assign n_slice     = in_n[i*PSUM_BW +: PSUM_BW];
        assign cnt_full[i] = (cnt_q == CNT_W'(CNT_MAX));
        assign ld_eff      = clr_loaded ? 1'b0 : ld_q;

        always_comb begin
            w_d   = w_q;
            ld_d  = ld_eff;
            acc_d = acc_q;
            cnt_d = cnt_q;
            out_d = out_q;
            vld_d = 1'b0;
            fwd_d = inst_in[i];
            if (proc_en) begin
                if (mode_os) begin
                    fwd_d[0] = 1'b0;  // load tokens have no meaning in OS
                    if (inst_in[i][1] && !cnt_full[i]) begin
                        acc_d = add_fn(acc_q, prod_fn(act_in[i], $signed(n_slice[BW-1:0])));
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // A load token is consumed by the first unloaded PE it meets.
                    if (inst_in[i][0] && !ld_eff) begin
                        w_d      = $signed(act_in[i]);
                        ld_d     = 1'b1;
                        fwd_d[0] = 1'b0;
                    end
                    if (inst_in[i][1]) begin
                        out_d = add_fn($signed(n_slice), prod_fn(act_in[i], w_q));
                        vld_d = 1'b1;
                    end
                end
            end
            if (drain_go) begin
                out_d = acc_q;
                vld_d = 1'b1;
            end
            if (state_q == OS_DRAIN) begin
                acc_d = '0;
                cnt_d = '0;
                fwd_d = 2'b00;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                w_q   <= '0;
                ld_q  <= 1'b0;
                acc_q <= '0;
                cnt_q <= '0;
                out_q <= '0;
                vld_q <= 1'b0;
                fwd_q <= 2'b00;
            end else begin
                w_q   <= w_d;
                ld_q  <= ld_d;
                acc_q <= acc_d;
                cnt_q <= cnt_d;
                out_q <= out_d;
                vld_q <= vld_d;
                fwd_q <= fwd_d;
            end
        end

        assign out_s[i*PSUM_BW +: PSUM_BW] = out_q;
        assign valid[i]    = vld_q;
        assign inst_out[i] = fwd_q;

        if (i > 0) begin : g_link
            assign inst_in[i] = inst_out[i-1];
        end

        // The last PE has nobody to forward its activation to.
        if (i < COL - 1) begin : g_act
            logic [BW-1:0] act_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) act_q <= '0;
                else       act_q <= act_in[i];
            end
            assign act_in[i+1] = act_q;
        end
    end

endmodule

// File: tb/tb_mac_row_ws_os.sv
module tb_mac_row_ws_os;
  localparam int BW = 4;
  localparam int PW = 16;
  localparam int COL = 8;
  localparam int W = 36;  // {cycle[15:0], column[3:0], value[15:0]}

  logic clk = 1'b0;
  logic reset, os, os_drain, busy, drain_err;
  logic [BW-1:0] in_w;
  logic [1:0] inst_w, dbg_state;
  logic [COL*PW-1:0] in_n, out_s;
  logic [COL-1:0] valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0;
  logic [W-1:0] exp_q[$];

`ifdef MAC_ROW_WS_OS_SAT_EN
  localparam logic [15:0] OVF_EXP = 16'h7FFF;
`else
  localparam logic [15:0] OVF_EXP = 16'h8030;  // -32720
`endif

  mac_row_ws_os #(.BW(BW), .PSUM_BW(PW), .COL(COL), .CNT_MAX(72)) dut (
    .clk(clk), .reset(reset), .os(os), .in_w(in_w), .inst_w(inst_w), .in_n(in_n),
    .os_drain(os_drain), .out_s(out_s), .valid(valid), .busy(busy),
    .drain_err(drain_err), .dbg_state_o(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 60 && busy !== 1'b0; n++) tick;
    check(tag, busy, 1'b0);
  endtask

  task automatic push(input int c, input int col, input logic [15:0] val);
    exp_q.push_back({16'(c), 4'(col), val});
  endtask

  // Accept-cycle drain: all columns expected one cycle later with value v.
  task automatic drain_expect(input logic [15:0] v);
    os_drain = 1'b1;
    c0 = cyc;
    for (int i = 0; i < COL; i++) push(c0 + 1, i, v);
    tick;
    os_drain = 1'b0;
    check("drain_busy", busy, 1'b1);
    check("drain_state", dbg_state, 2'd3);
    check("drain_no_err", drain_err, 1'b0);
    tick;
    check("drain_idle", busy, 1'b0);
    check("drain_hold_out", out_s, {COL{v}});
    check("drain_valid_low", valid, '0);
  endtask

  task automatic os_exec(input int n);
    os = 1'b1; in_w = 4'd3; inst_w = 2'b10;
    repeat (n) tick;
    inst_w = 2'b00; in_w = 4'd0;
    repeat (10) tick;
  endtask

  // scoreboard: every valid column pops one expected {cycle, column, value}
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int i = 0; i < COL; i++) begin
        if (valid[i] === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_valid col %0d cycle %0d value %0h expected none", i, cyc,
                   out_s[i*PW +: PW]);
          end else begin
            check("result", {16'(cyc), 4'(i), out_s[i*PW +: PW]}, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; os = 1'b0; in_w = '0; inst_w = '0; in_n = '0; os_drain = 1'b0;
    repeat (3) tick;
    check("rst_out", out_s, '0);
    check("rst_valid", valid, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", drain_err, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    reset = 1'b0;
    tick;

    // WS: weights i-3 streamed in, then one execute with activation 2
    os = 1'b0;
    for (int k = 0; k < COL; k++) begin
      in_w = 4'(k - 3);
      inst_w = 2'b01;
      tick;
    end
    check("ws_busy", busy, 1'b1);
    check("ws_state", dbg_state, 2'd1);
    in_w = 4'd2; inst_w = 2'b10; in_n = '0;
    c0 = cyc;
    for (int i = 0; i < COL; i++) push(c0 + i + 1, i, 16'(2 * (i - 3)));
    tick;
    inst_w = 2'b00; in_w = '0;
    wait_idle("ws_idle");
    check("ws_hold_out0", out_s[15:0], 16'hFFFA);

    // OS: weight 1, activation 3, full 72 accumulations then drain
    in_n = {COL{16'd1}};
    os_exec(72);
    check("os_busy", busy, 1'b1);
    check("os_state", dbg_state, 2'd2);
    drain_expect(16'd216);

    // OS: premature drain rejected, accumulators keep going afterwards
    os_exec(10);
    os_drain = 1'b1;
    tick;
    os_drain = 1'b0;
    check("early_drain_err", drain_err, 1'b1);
    check("early_drain_state", dbg_state, 2'd2);
    check("early_drain_valid", valid, '0);
    tick;
    check("early_drain_err_pulse", drain_err, 1'b0);
    os_exec(62);
    drain_expect(16'd216);

    // Reset in the middle of OS accumulation
    os = 1'b1; in_w = 4'd3; inst_w = 2'b10;
    repeat (5) tick;
    reset = 1'b1;
    inst_w = 2'b00;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_out", out_s, '0);
    tick;
    reset = 1'b0;
    tick;
    inst_w = 2'b10; os_drain = 1'b1;
    tick;
    inst_w = 2'b00; os_drain = 1'b0;
    check("restart_drain_err", drain_err, 1'b1);
    check("restart_out", out_s, '0);
    check("restart_valid", valid, '0);
    check("restart_busy", busy, 1'b1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;

    // WS overflow: 32767 + 7*7
    os = 1'b0; in_n = '0; in_n[15:0] = 16'd32767;
    in_w = 4'd7; inst_w = 2'b01;
    tick;
    inst_w = 2'b10;
    c0 = cyc;
    push(c0 + 1, 0, OVF_EXP);
    for (int i = 1; i < COL; i++) push(c0 + i + 1, i, 16'd0);
    tick;
    inst_w = 2'b00; in_w = '0;
    wait_idle("ovf_idle");

    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
